// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with oversampled start/data/stop sampling and a one-entry output register
//
// Ports:
//   clk        bus clock, rising edge
//   rst        synchronous active-high reset
//   clk_en     oversample tick (OVERSAMPLE per bit period)
//   rx         asynchronous serial input, idle high, LSB first
//   din        received byte, stable while valid is high
//   valid      din holds an unread byte
//   ready      consumer takes din on valid & ready
//   frame_err  one-cycle pulse when a stop bit samples low
//   overrun    sticky; a finished byte was dropped while valid was high

module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       rx,
  output logic [7:0] din,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic          rx_m;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  logic          stop_hit;
  logic          deliver;
  logic          bad_stop;
  logic          handshake;

  // Stop-bit decision point: both outcomes are registered on the same edge
  // as the FSM leaves STOP, so outputs appear the following cycle.
  always_comb begin
    stop_hit  = 1'b0;
    deliver   = 1'b0;
    bad_stop  = 1'b0;
    handshake = valid & ready;
    stop_hit  = (state == S_STOP) && clk_en && (tick_cnt == FULL_LAST);
    deliver   = stop_hit && rx_s;
    bad_stop  = stop_hit && !rx_s;
  end

  // Synchronizer and receive FSM. The synchronizer runs every cycle; all
  // other receive state only moves on clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      if (clk_en) begin
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state    <= S_START;
              tick_cnt <= '0;
            end
          end
          S_START: begin
            // Mid-start check rejects glitches shorter than half a bit.
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? S_IDLE : S_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= S_STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              state    <= rx_s ? S_IDLE : S_WAIT_IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            // A break keeps us here silently until the line returns high.
            if (rx_s) begin
              state <= S_IDLE;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Output register. A delivery coinciding with a handshake replaces the
  // consumed byte; a delivery into an unread byte is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      din       <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (deliver && (!valid || handshake)) begin
        din   <= shift;
        valid <= 1'b1;
      end else if (handshake) begin
        valid <= 1'b0;
      end
      if (deliver && valid && !handshake) begin
        overrun <= 1'b1;
      end else if (handshake) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed frames and a back-to-back burst

module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic       rx;
  logic [7:0] din;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int         vectors;
  int         miscompares;
  int         fe_count;
  int         fe_base;
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .rx        (rx),
    .din       (din),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (16) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain got=%0d_pending expected=0_pending", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) fe_count++;
        if (valid && ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_valid got=%02h expected=none", din);
          end else begin
            e = exp_q.pop_front();
            if (din !== e) begin
              miscompares++;
              $display("FAIL byte got=%02h expected=%02h", din, e);
            end
          end
        end
      end
    end
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] partial;
    vectors     = 0;
    miscompares = 0;
    fe_count    = 0;
    rst    = 1'b1;
    clk_en = 1'b1;
    rx     = 1'b1;
    ready  = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) tick();
    chk("reset_din", 32'(din), 32'h00);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_frame_err", 32'(frame_err), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    rst = 1'b0;
    repeat (20) tick();

    // Single frame 0xA5
    fe_base = fe_count;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_drain("a5", 40);
    chk("a5_frame_err_count", 32'(fe_count - fe_base), 32'd0);
    chk("a5_overrun", 32'(overrun), 32'h0);

    // False start: short low pulse, then a real 0x3C frame
    fe_base = fe_count;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_drain("3c", 40);
    chk("false_start_frame_err_count", 32'(fe_count - fe_base), 32'd0);

    // Bad stop bit followed by a break, then a good 0x55 frame
    fe_base = fe_count;
    send_frame(8'h81, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("break_frame_err_count", 32'(fe_count - fe_base), 32'd1);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_drain("55", 40);
    chk("after_break_frame_err_count", 32'(fe_count - fe_base), 32'd1);

    // Overrun: consumer stalled across two frames; second byte is dropped
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) tick();
    chk("ovr_din", 32'(din), 32'h11);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_overrun", 32'(overrun), 32'h1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovr_valid_after_ack", 32'(valid), 32'h0);
    chk("ovr_overrun_after_ack", 32'(overrun), 32'h0);
    wait_drain("11", 4);
    ready = 1'b1;
    repeat (10) tick();

    // Reset in the middle of bit 3, then 0xF0
    partial = 8'hC3;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(partial[i]);
    rx = partial[3];
    repeat (8) tick();
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_din", 32'(din), 32'h00);
    chk("midreset_valid", 32'(valid), 32'h0);
    chk("midreset_frame_err", 32'(frame_err), 32'h0);
    chk("midreset_overrun", 32'(overrun), 32'h0);
    repeat (200) tick();
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b1);
    wait_drain("f0", 40);

    // Burst of 32 back-to-back random frames, as from a transmitter loopback
    fe_base = fe_count;
    for (int k = 0; k < 32; k++) begin
      r = 8'($urandom_range(0, 255));
      exp_q.push_back(r);
      send_frame(r, 1'b1);
    end
    wait_drain("burst", 40);
    chk("burst_frame_err_count", 32'(fe_count - fe_base), 32'd0);
    chk("burst_overrun", 32'(overrun), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
